// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - upstream fifo read port and downstream stream bundle
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8
);
    logic             fifo_re;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_val;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    modport master (
        output fifo_re, m_valid, m_data, m_last,
        input  fifo_empty, fifo_dout, fifo_val, m_ready
    );

    modport slave (
        input  fifo_re, m_valid, m_data, m_last,
        output fifo_empty, fifo_dout, fifo_val, m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - credit-based fifo reader feeding a registered, burst-framed stream
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 4,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_stream_if.master  bus,
    output logic              busy,
    output logic              ovf_err
);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    logic [WIDTH-1:0]  mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d, inflight_q, inflight_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              ovf_q, ovf_d;
    logic              post_rst_q;
    logic              rd_acc, wr_en, pop, m_valid_w;

    // Reads are issued only against free credit, so a returning word always has a slot.
    always_comb begin
        rd_acc     = !rst && !post_rst_q && !bus.fifo_empty && ((occ_q + inflight_q) < DEPTH_C);
        wr_en      = bus.fifo_val && (inflight_q != '0);
        m_valid_w  = !rst && (occ_q != '0);
        pop        = m_valid_w && bus.m_ready;

        inflight_d = inflight_q + CNT_W'(rd_acc) - CNT_W'(wr_en);
        occ_d      = occ_q + CNT_W'(wr_en) - CNT_W'(pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);
        end

        // A stray return in the cycle after reset belongs to an aborted read.
        ovf_d = ovf_q || (bus.fifo_val && (inflight_q == '0) && !post_rst_q);
    end

    always_ff @(posedge clk) begin
        post_rst_q <= rst;
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            beat_q     <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            ovf_q      <= ovf_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= bus.fifo_dout;
            end
        end
    end

    assign bus.fifo_re = rd_acc;
    assign bus.m_valid = m_valid_w;
    assign bus.m_data  = mem_q[rd_ptr_q];
    assign bus.m_last  = m_valid_w && (beat_q == BEAT_MAX);
    assign busy        = !rst && ((inflight_q != '0) || (occ_q != '0));
    assign ovf_err     = ovf_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench with a variable-latency upstream fifo model
module tb_fifo_rd_stream;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int BLEN  = 16;

    logic clk = 1'b0;
    logic rst;
    logic busy, ovf_err;

    fifo_rd_stream_if #(.WIDTH(W)) bus ();

    fifo_rd_stream #(.WIDTH(W), .BUF_DEPTH(DEPTH), .BURST_LEN(BLEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [W-1:0] d;
    } pend_t;

    logic [W-1:0] up_q  [$];
    logic [W-1:0] exp_q [$];
    pend_t        pipe_q[$];

    int cyc, last_due, exp_beat, ready_mode, lat_min, lat_max;
    int n_rd, n_beats, n_last, max_out, first_beat_cyc, last_beat_cyc;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic drive_ready();
        case (ready_mode)
            1:       bus.m_ready = 1'b1;
            2:       bus.m_ready = ($urandom_range(3, 0) != 0);
            default: bus.m_ready = 1'b0;
        endcase
    endtask

    task automatic drive_inputs();
        pend_t p;
        if (pipe_q.size() != 0 && pipe_q[0].due == cyc) begin
            p = pipe_q.pop_front();
            bus.fifo_val  = 1'b1;
            bus.fifo_dout = p.d;
        end else begin
            bus.fifo_val  = 1'b0;
            bus.fifo_dout = W'($urandom);
        end
        bus.fifo_empty = (up_q.size() == 0);
        drive_ready();
    endtask

    // Observe the settled pre-edge handshakes, then advance the upstream model one cycle.
    task automatic tick();
        pend_t        p;
        int           due;
        logic [W-1:0] w;
        @(negedge clk);
        if (bus.m_valid && bus.m_ready) begin
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check_eq("m_data", 32'(bus.m_data), 32'(w));
                check_eq("m_last", 32'(bus.m_last), 32'(exp_beat == BLEN - 1));
                exp_beat = (exp_beat == BLEN - 1) ? 0 : exp_beat + 1;
            end
            n_beats++;
            if (bus.m_last) n_last++;
            if (n_beats == 1) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
        end
        if (bus.fifo_re) begin
            check_eq("rd_nonempty", 32'(up_q.size() != 0), 32'd1);
            if (up_q.size() != 0) begin
                p.d = up_q.pop_front();
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                p.due    = due;
                last_due = due;
                pipe_q.push_back(p);
            end
            n_rd++;
        end
        if (n_rd - n_beats > max_out) max_out = n_rd - n_beats;
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic load(input int n, input bit rnd);
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? W'($urandom) : W'(i + 1);
            up_q.push_back(w);
            exp_q.push_back(w);
        end
        bus.fifo_empty = (up_q.size() == 0);
    endtask

    task automatic clr_stats();
        n_rd = 0; n_beats = 0; n_last = 0; max_out = 0;
        first_beat_cyc = 0; last_beat_cyc = 0;
    endtask

    task automatic run_until_drained(input int bound);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < bound) begin
            tick();
            k++;
        end
        check_eq("drain_in_time", 32'(k < bound), 32'd1);
    endtask

    task automatic do_reset(input bit inject);
        rst = 1'b1;
        bus.fifo_val   = 1'b0;
        bus.fifo_empty = 1'b0;
        pipe_q.delete();
        up_q.delete();
        exp_q.delete();
        exp_beat = 0;
        #1;
        check_eq("rst_fifo_re", 32'(bus.fifo_re), 32'd0);
        check_eq("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_eq("rst_m_last",  32'(bus.m_last),  32'd0);
        check_eq("rst_busy",    32'(busy),        32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (inject) begin
            bus.fifo_val  = 1'b1;
            bus.fifo_dout = 8'h55;
        end
        #1;
        check_eq("post_rst_fifo_re", 32'(bus.fifo_re), 32'd0);
        check_eq("post_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_eq("post_rst_m_last",  32'(bus.m_last),  32'd0);
        check_eq("post_rst_busy",    32'(busy),        32'd0);
        check_eq("post_rst_ovf",     32'(ovf_err),     32'd0);
        bus.fifo_empty = 1'b1;
        last_due = cyc;
        tick();
        check_eq("post_rst_val_ignored", 32'(ovf_err),     32'd0);
        check_eq("post_rst_no_beat",     32'(bus.m_valid), 32'd0);
        check_eq("post_rst_idle",        32'(busy),        32'd0);
    endtask

    initial begin
        logic [W-1:0] first;
        int bad, k;
        rst = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_val   = 1'b0;
        bus.fifo_dout  = '0;
        bus.m_ready    = 1'b0;
        cyc = 0; last_due = 0; exp_beat = 0;
        lat_min = 1; lat_max = 1; ready_mode = 1;
        clr_stats();
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        // streaming 0x01..0x20 at full rate
        clr_stats();
        ready_mode = 1; drive_ready();
        load(32, 1'b0);
        run_until_drained(300);
        check_eq("stream_beats", 32'(n_beats), 32'd32);
        check_eq("stream_lasts", 32'(n_last), 32'd2);
        check_eq("stream_no_gap", 32'(last_beat_cyc - first_beat_cyc), 32'd31);

        // backpressure with 10 words waiting
        clr_stats();
        ready_mode = 0; drive_ready();
        load(10, 1'b1);
        first = exp_q[0];
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.m_valid && bus.m_data !== first) bad++;
        end
        check_eq("bp_reads", 32'(n_rd), 32'(DEPTH));
        check_eq("bp_fifo_re_off", 32'(bus.fifo_re), 32'd0);
        check_eq("bp_m_valid", 32'(bus.m_valid), 32'd1);
        check_eq("bp_m_data", 32'(bus.m_data), 32'(first));
        check_eq("bp_hold_stable", 32'(bad), 32'd0);
        ready_mode = 1; drive_ready();
        run_until_drained(300);
        check_eq("bp_beats", 32'(n_beats), 32'd10);

        // empty upstream fifo stays idle, then a single word
        clr_stats();
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.fifo_re || bus.m_valid || busy) bad++;
        end
        check_eq("empty_idle", 32'(bad), 32'd0);
        load(1, 1'b1);
        run_until_drained(50);
        check_eq("single_beats", 32'(n_beats), 32'd1);
        check_eq("single_busy", 32'(busy), 32'd0);

        // 64 random words, random latency, fill then random ready
        clr_stats();
        lat_min = 1; lat_max = 4;
        ready_mode = 0; drive_ready();
        load(64, 1'b1);
        repeat (10) tick();
        ready_mode = 2; drive_ready();
        run_until_drained(3000);
        check_eq("rand_beats", 32'(n_beats), 32'd64);
        check_eq("rand_credit_bound", 32'(max_out <= DEPTH), 32'd1);
        check_eq("rand_busy", 32'(busy), 32'd0);

        // unexpected return while no read is outstanding
        lat_min = 1; lat_max = 1;
        ready_mode = 1; drive_ready();
        bus.fifo_val  = 1'b1;
        bus.fifo_dout = 8'hAA;
        tick();
        check_eq("ovf_set", 32'(ovf_err), 32'd1);
        check_eq("ovf_no_beat", 32'(bus.m_valid), 32'd0);
        check_eq("ovf_not_busy", 32'(busy), 32'd0);
        repeat (10) tick();
        check_eq("ovf_sticky", 32'(ovf_err), 32'd1);

        // reset mid-burst with words buffered
        do_reset(1'b0);
        check_eq("ovf_cleared", 32'(ovf_err), 32'd0);
        clr_stats();
        ready_mode = 1; drive_ready();
        load(8, 1'b1);
        k = 0;
        while (n_beats < 5 && k < 100) begin
            tick();
            k++;
        end
        ready_mode = 0; drive_ready();
        repeat (6) tick();
        check_eq("mid_beats", 32'(n_beats), 32'd5);
        check_eq("mid_buffered", 32'(n_rd - n_beats), 32'd3);
        check_eq("mid_busy", 32'(busy), 32'd1);
        do_reset(1'b1);
        clr_stats();
        ready_mode = 1; drive_ready();
        load(16, 1'b0);
        run_until_drained(300);
        check_eq("after_rst_beats", 32'(n_beats), 32'd16);
        check_eq("after_rst_lasts", 32'(n_last), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (must equal the width of the feeding fifo).
REQ-002 SHALL have parameter BUF_DEPTH, default 4, output buffer entries (power of two, >= 2).
REQ-003 SHALL have parameter BURST_LEN, default 16, beats per burst for m_last framing (>= 1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fifo_re  output  1  read request to the upstream fifo.
REQ-007 SHALL have port fifo_empty  input  1  upstream fifo empty flag.
REQ-008 SHALL have port fifo_dout  input  WIDTH  upstream fifo read data.
REQ-009 SHALL have port fifo_val  input  1  fifo_dout valid this cycle (one pulse per accepted read).
REQ-010 SHALL have port m_valid  output  1  downstream stream data valid.
REQ-011 SHALL have port m_data  output  WIDTH  downstream stream data.
REQ-012 SHALL have port m_last  output  1  last beat of the current burst.
REQ-013 SHALL have port m_ready  input  1  downstream accepts the beat.
REQ-014 SHALL have port busy  output  1  reads in flight or buffer non-empty.
REQ-015 SHALL have port ovf_err  output  1  sticky error: unexpected fifo_val.

Function
REQ-016 SHALL drive fifo_re combinationally = !rst && !fifo_empty && (occ + inflight) < BUF_DEPTH; an accepted read is fifo_re high in a cycle.
REQ-017 SHALL keep inflight counter (clog2(BUF_DEPTH)+1 bits): +1 on accepted read, -1 on fifo_val with inflight != 0, unchanged when both occur.
REQ-018 SHALL make no assumption on fifo read latency; correctness relies only on the inflight credit count.
REQ-019 SHALL write fifo_dout into the circular buffer at the write pointer on fifo_val with inflight != 0; occ +1, write pointer wraps BUF_DEPTH-1 -> 0.
REQ-020 SHALL drive m_valid = (occ != 0) and m_data = entry at read pointer, both from registers (no combinational path from fifo_* to m_*).
REQ-021 SHALL pop on m_valid && m_ready: occ -1, read pointer wraps BUF_DEPTH-1 -> 0; simultaneous write and pop leave occ unchanged.
REQ-022 SHALL hold m_data and m_last stable while m_valid && !m_ready.
REQ-023 SHALL never exceed occ + inflight == BUF_DEPTH, so a buffer write never meets a full buffer.
REQ-024 SHALL keep beat counter 0..BURST_LEN-1, increment on each handshake, wrap to 0 after BURST_LEN-1; m_last = m_valid && beat == BURST_LEN-1 (BURST_LEN=1: m_last = m_valid).
REQ-025 SHALL set ovf_err on fifo_val while inflight == 0, drop that data, leave other state unchanged; cleared only by rst.
REQ-026 SHALL drive busy = (inflight != 0) || (occ != 0).
REQ-027 SHALL give min latency fifo_val -> m_valid of exactly 1 cycle.

Reset
REQ-028 SHALL on rst clear inflight, occ, both pointers, beat counter, ovf_err and all buffer entries to 0; fifo_re, m_valid, m_last, busy are 0 during and the cycle after reset.
REQ-029 SHALL treat rst mid-transfer as abort: buffered and in-flight data discarded, fifo_val in the cycle after reset ignored without setting ovf_err.

Verification
REQ-030 SHALL cover streaming: fifo preloaded 0x01..0x20, m_ready=1 -> m_data 0x01..0x20 in order, no gaps after first beat, m_last on 0x10 and 0x20 only.
REQ-031 SHALL cover backpressure: m_ready=0 with 10 words in fifo -> exactly BUF_DEPTH=4 reads accepted, then fifo_re=0; m_data=first word held stable; m_ready=1 releases remaining 10 words in order.
REQ-032 SHALL cover empty: fifo_empty=1 -> fifo_re=0, m_valid=0, busy=0 indefinitely; one word written -> exactly one beat out, busy returns 0.
REQ-033 SHALL cover simultaneous write/pop at occ=BUF_DEPTH-1 with m_ready=1 -> occ unchanged, no loss or duplication across 64 random words, pointers wrap correctly.
REQ-034 SHALL cover error: fifo_val forced high with inflight=0 -> ovf_err=1 next cycle, m_valid unchanged, ovf_err stays 1 until rst.
REQ-035 SHALL cover reset mid-burst: rst at beat 5 with 3 words buffered -> m_valid=0, busy=0, next burst m_last on its 16th beat.
